// File: rtl/sc_acc_pkg.sv
// Shared types and default sizing for the stochastic bitstream accumulator.
package sc_acc_pkg;

    localparam int DEF_WIN_LOG2 = 8;
    localparam int DEF_SKIP     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } acc_state_e;

endpackage

// File: rtl/sc_bitstream_acc_if.sv
// Handshake/data bundle between the accumulator and its upstream MAC / downstream consumer.
// oBip exists only when SC_ACC_BIPOLAR_EN is defined.
interface sc_bitstream_acc_if #(parameter int WIN_LOG2 = 8);
    logic                start;
    logic                iBit;
    logic                oLoad;
    logic                oBusy;
    logic [WIN_LOG2:0]   oCnt;
    logic                oValid;
    logic                iReady;
`ifdef SC_ACC_BIPOLAR_EN
    logic signed [WIN_LOG2+1:0] oBip;
`endif

    modport master (
        output start, iBit, iReady,
        input  oLoad, oBusy, oCnt, oValid
`ifdef SC_ACC_BIPOLAR_EN
      , input  oBip
`endif
    );

    modport slave (
        input  start, iBit, iReady,
        output oLoad, oBusy, oCnt, oValid
`ifdef SC_ACC_BIPOLAR_EN
      , output oBip
`endif
    );
endinterface

// File: rtl/sc_win_cnt.sv
// Loadable down-counter shared by the skip and window phases; tc flags the last counted cycle.
module sc_win_cnt #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == W'(1));
endmodule

// File: rtl/sc_bitstream_acc.sv
// Counts ones of a unipolar stochastic bitstream over a 2^WIN_LOG2-cycle window after SKIP flush cycles.
// Optional signed bipolar result under macro SC_ACC_BIPOLAR_EN.
module sc_bitstream_acc
    import sc_acc_pkg::*;
#(
    parameter int WIN_LOG2 = DEF_WIN_LOG2,
    parameter int SKIP     = DEF_SKIP
) (
    input  logic            clk,
    input  logic            rst,
    sc_bitstream_acc_if.slave bus
);
    localparam int             CW       = WIN_LOG2 + 1;
    localparam logic [CW-1:0]  WIN_LEN  = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [CW-1:0]  SKIP_LEN = CW'(SKIP);

    acc_state_e     state_q, state_d;
    logic [CW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           tmr_ld, tmr_en, tmr_tc;
    logic [CW-1:0]  tmr_val;

    sc_win_cnt #(.W(CW)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_ld),
        .load_val (tmr_val),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        tmr_ld  = 1'b0;
        tmr_en  = 1'b0;
        tmr_val = WIN_LEN;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d  = '0;
                    tmr_ld = 1'b1;
                    if (SKIP == 0) begin
                        state_d = ST_RUN;
                    end else begin
                        tmr_val = SKIP_LEN;
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    tmr_ld  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                tmr_en = 1'b1;
                acc_d  = acc_q + CW'(bus.iBit);
                // Latch the total including the final bit; oCnt holds it until the next run ends.
                if (tmr_tc) begin
                    cnt_d   = acc_d;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.iReady) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d == ST_SKIP) || (state_d == ST_RUN);
    end

`ifdef SC_ACC_BIPOLAR_EN
    logic signed [CW:0] bip_q, bip_d;
    always_comb bip_d = $signed({cnt_d, 1'b0}) - $signed({2'b00, WIN_LEN[CW-2:0]} | (CW+1)'(WIN_LEN));
    assign bus.oBip = bip_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SC_ACC_BIPOLAR_EN
            bip_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef SC_ACC_BIPOLAR_EN
            bip_q   <= bip_d;
`endif
        end
    end

    // Load pulse must reach the MAC in the acceptance cycle, so it stays combinational.
    assign bus.oLoad  = (state_q == ST_IDLE) && bus.start && !rst;
    assign bus.oBusy  = busy_q;
    assign bus.oValid = valid_q;
    assign bus.oCnt   = cnt_q;
endmodule
